// File: rtl/spi_host_fifo_pkg.sv
// Shared register offsets, register layouts and engine state encoding
// for the SPI host with TX/RX FIFOs.
package spi_host_fifo_pkg;

  localparam logic [11:0] ADDR_TX     = 12'h000;
  localparam logic [11:0] ADDR_RX     = 12'h004;
  localparam logic [11:0] ADDR_STATUS = 12'h008;
  localparam logic [11:0] ADDR_CTRL   = 12'h00C;

  localparam logic [31:0] CTRL_WMASK  = 32'h0F1F_FFFF;

  typedef struct packed {
    logic [3:0]  rsvd1;
    logic [3:0]  cs_sel;
    logic [2:0]  rsvd0;
    logic        txie;
    logic        rxie;
    logic        rx_en;
    logic        cpha;
    logic        cpol;
    logic [15:0] clkdiv;
  } ctrl_t;

  typedef struct packed {
    logic [7:0] rsvd2;
    logic [7:0] rx_depth;
    logic [8:0] rsvd1;
    logic       rx_ovf;
    logic       tx_ovf;
    logic       busy;
    logic       rx_empty;
    logic       rx_full;
    logic       tx_empty;
    logic       tx_full;
  } status_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD
  } spi_state_e;

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous FIFO with optional fall-through when empty (Pass).
// Full is reported from the registered count, so a push while full is refused even if a pop happens.
module prim_fifo_sync #(
  parameter int Width = 16,
  parameter bit Pass  = 1'b1,
  parameter int Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       wvalid_i,
  output logic                       wready_o,
  input  logic [Width-1:0]           wdata_i,
  output logic                       rvalid_o,
  input  logic                       rready_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic [$clog2(Depth+1)-1:0] depth_o
);
  localparam int PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int DepthW = $clog2(Depth+1);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [DepthW-1:0] cnt_q;
  logic              empty, pass, do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign full_o   = (cnt_q == DepthW'(Depth));
  assign depth_o  = cnt_q;
  assign pass     = Pass && empty;
  assign wready_o = ~full_o;
  assign rvalid_o = ~empty | (pass & wvalid_i);
  assign rdata_o  = pass ? wdata_i : mem_q[rptr_q];
  assign do_push  = wvalid_i & wready_o & ~(pass & rready_i);
  assign do_pop   = rready_i & ~empty;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= (wptr_q == PtrW'(Depth-1)) ? '0 : wptr_q + 1'b1;
      if (do_pop)  rptr_q <= (rptr_q == PtrW'(Depth-1)) ? '0 : rptr_q + 1'b1;
      cnt_q <= cnt_q + DepthW'(do_push) - DepthW'(do_pop);
    end
  end
endmodule

// File: rtl/spi_shift_engine.sv
// SPI transfer engine: burst sequencing FSM, SCK half-period down-counter and shift registers.
// state       | meaning
// ST_IDLE     | waiting for TX data; config latched on exit
// ST_CS_SETUP | CS asserted, waiting CLKDIV+1 cycles before the first word
// ST_SHIFT    | shifting words; 2*DataWidth half-periods each
// ST_CS_HOLD  | CS still asserted for CLKDIV+1 cycles after the last word
module spi_shift_engine
  import spi_host_fifo_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int NumCs     = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tx_valid_i,
  input  logic [DataWidth-1:0] tx_data_i,
  input  logic [15:0]          clkdiv_i,
  input  logic                 cpol_i,
  input  logic                 cpha_i,
  input  logic [3:0]           cs_sel_i,
  input  logic                 spi_rx_i,
  output logic                 tx_pop_o,
  output logic                 word_done_o,
  output logic [DataWidth-1:0] rx_data_o,
  output logic                 busy_o,
  output logic                 sck_o,
  output logic                 spi_tx_o,
  output logic [NumCs-1:0]     cs_no
);
  localparam int HalfW = $clog2(2*DataWidth+1);

  spi_state_e           state_q, state_d;
  logic [15:0]          cnt_q, cnt_d, clkdiv_q, clkdiv_d;
  logic [HalfW-1:0]     half_q, half_d, half_nxt;
  logic [DataWidth-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic                 sck_q, sck_d, cpol_q, cpol_d, cpha_q, cpha_d;
  logic [NumCs-1:0]     cs_q, cs_d, cs_dec;
  logic                 start;

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;      half_d = half_q;
    tx_sh_d = tx_sh_q;  rx_sh_d = rx_sh_q;  sck_d = sck_q;  cs_d = cs_q;
    clkdiv_d = clkdiv_q; cpol_d = cpol_q;   cpha_d = cpha_q;
    tx_pop_o = 1'b0;    word_done_o = 1'b0; start = 1'b0;
    half_nxt = half_q + HalfW'(1);
    cs_dec = '1;
    for (int i = 0; i < NumCs; i++) cs_dec[i] = (cs_sel_i != 4'(i));

    unique case (state_q)
      ST_IDLE: begin
        if (tx_valid_i) begin
          clkdiv_d = clkdiv_i;
          cpol_d   = cpol_i;
          cpha_d   = cpha_i;
          sck_d    = cpol_i;
          cs_d     = cs_dec;
          cnt_d    = clkdiv_i;
          state_d  = ST_CS_SETUP;
        end
      end
      ST_CS_SETUP: begin
        if (cnt_q == '0) start = 1'b1;
        else             cnt_d = cnt_q - 16'd1;
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (half_nxt == HalfW'(2*DataWidth)) begin
          word_done_o = 1'b1;
          if (tx_valid_i) begin
            start = 1'b1;
          end else begin
            sck_d   = cpol_q;
            cnt_d   = clkdiv_q;
            state_d = ST_CS_HOLD;
          end
        end else begin
          // odd half-periods begin at the sample edge, even ones at the shift edge
          half_d = half_nxt;
          cnt_d  = clkdiv_q;
          sck_d  = cpol_q ^ cpha_q ^ half_nxt[0];
          if (half_nxt[0]) rx_sh_d = {rx_sh_q[DataWidth-2:0], spi_rx_i};
          else             tx_sh_d = tx_sh_q << 1;
        end
      end
      ST_CS_HOLD: begin
        if (cnt_q == '0) begin
          cs_d    = '1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      tx_pop_o = 1'b1;
      tx_sh_d  = tx_data_i;
      half_d   = '0;
      cnt_d    = clkdiv_q;
      sck_d    = cpol_q ^ cpha_q;
      state_d  = ST_SHIFT;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      half_q   <= '0;
      tx_sh_q  <= '0;
      rx_sh_q  <= '0;
      sck_q    <= 1'b0;
      cs_q     <= '1;
      clkdiv_q <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      tx_sh_q  <= tx_sh_d;
      rx_sh_q  <= rx_sh_d;
      sck_q    <= sck_d;
      cs_q     <= cs_d;
      clkdiv_q <= clkdiv_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
    end
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign sck_o     = sck_q;
  assign spi_tx_o  = tx_sh_q[DataWidth-1];
  assign cs_no     = cs_q;
  assign rx_data_o = rx_sh_q;
endmodule

// File: rtl/spi_host_fifo_ctrl.sv
// Memory-mapped SPI host: register file, bus decode and TX/RX FIFOs around the shift engine.
module spi_host_fifo_ctrl
  import spi_host_fifo_pkg::*;
#(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 12_500_000,
  parameter int DataWidth      = 8,
  parameter int TxDepth        = 16,
  parameter int RxDepth        = 16,
  parameter int NumCs          = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             device_req_i,
  input  logic [31:0]      device_addr_i,
  input  logic             device_we_i,
  input  logic [3:0]       device_be_i,
  input  logic [31:0]      device_wdata_i,
  output logic             device_rvalid_o,
  output logic [31:0]      device_rdata_o,
  input  logic             spi_rx_i,
  output logic             spi_tx_o,
  output logic             sck_o,
  output logic [NumCs-1:0] cs_no,
  output logic             irq_o
);
  localparam logic [15:0] ClkDivRst = 16'(ClockFrequency / (2 * BaudRate) - 1);

  ctrl_t       ctrl_q, ctrl_d;
  status_t     status;
  logic        tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, rvalid_q;
  logic [31:0] rdata_q, rdata_d;
  logic [11:0] addr;
  logic        wr, rd, tx_push, rx_pop, rx_push;
  logic        tx_wready, tx_rvalid, tx_full, rx_wready, rx_rvalid, rx_full;
  logic        eng_pop, eng_done, eng_busy;
  logic [DataWidth-1:0]         tx_rdata, rx_rdata, eng_rx_data;
  logic [$clog2(RxDepth+1)-1:0] rx_depth;
  logic [$clog2(TxDepth+1)-1:0] unused_tx_depth;
  logic                         unused_bus;

  assign addr       = device_addr_i[11:0];
  assign wr         = device_req_i & device_we_i;
  assign rd         = device_req_i & ~device_we_i;
  assign tx_push    = wr && (addr == ADDR_TX);
  assign rx_pop     = rd && (addr == ADDR_RX);
  assign rx_push    = eng_done & ctrl_q.rx_en;
  assign unused_bus = ^{device_be_i, device_addr_i[31:12], unused_tx_depth};

  prim_fifo_sync #(.Width(DataWidth), .Pass(1'b0), .Depth(TxDepth)) u_tx_fifo (
    .clk_i, .rst_ni(~rst_i), .clr_i(1'b0),
    .wvalid_i(tx_push), .wready_o(tx_wready), .wdata_i(device_wdata_i[DataWidth-1:0]),
    .rvalid_o(tx_rvalid), .rready_i(eng_pop), .rdata_o(tx_rdata),
    .full_o(tx_full), .depth_o(unused_tx_depth)
  );

  prim_fifo_sync #(.Width(DataWidth), .Pass(1'b0), .Depth(RxDepth)) u_rx_fifo (
    .clk_i, .rst_ni(~rst_i), .clr_i(1'b0),
    .wvalid_i(rx_push), .wready_o(rx_wready), .wdata_i(eng_rx_data),
    .rvalid_o(rx_rvalid), .rready_i(rx_pop), .rdata_o(rx_rdata),
    .full_o(rx_full), .depth_o(rx_depth)
  );

  spi_shift_engine #(.DataWidth(DataWidth), .NumCs(NumCs)) u_engine (
    .clk_i, .rst_i,
    .tx_valid_i(tx_rvalid), .tx_data_i(tx_rdata),
    .clkdiv_i(ctrl_q.clkdiv), .cpol_i(ctrl_q.cpol), .cpha_i(ctrl_q.cpha), .cs_sel_i(ctrl_q.cs_sel),
    .spi_rx_i, .tx_pop_o(eng_pop), .word_done_o(eng_done), .rx_data_o(eng_rx_data),
    .busy_o(eng_busy), .sck_o, .spi_tx_o, .cs_no
  );

  always_comb begin
    status          = '0;
    status.tx_full  = tx_full;
    status.tx_empty = ~tx_rvalid;
    status.rx_full  = rx_full;
    status.rx_empty = ~rx_rvalid;
    status.busy     = eng_busy;
    status.tx_ovf   = tx_ovf_q;
    status.rx_ovf   = rx_ovf_q;
    status.rx_depth = 8'(rx_depth);
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
    rdata_d  = '0;
    if (wr && addr == ADDR_CTRL) ctrl_d = ctrl_t'(device_wdata_i & CTRL_WMASK);
    if (wr && addr == ADDR_STATUS) begin
      if (device_wdata_i[5]) tx_ovf_d = 1'b0;
      if (device_wdata_i[6]) rx_ovf_d = 1'b0;
    end
    // set after clear so a coincident overflow wins over write-1-to-clear
    if (tx_push && !tx_wready) tx_ovf_d = 1'b1;
    if (rx_push && !rx_wready) rx_ovf_d = 1'b1;
    if (rd) begin
      case (addr)
        ADDR_RX:     rdata_d = rx_rvalid ? 32'(rx_rdata) : '0;
        ADDR_STATUS: rdata_d = status;
        ADDR_CTRL:   rdata_d = ctrl_q;
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q   <= ctrl_t'({16'h0000, ClkDivRst});
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      rvalid_q <= device_req_i;
      rdata_q  <= rdata_d;
    end
  end

  assign device_rvalid_o = rvalid_q;
  assign device_rdata_o  = rdata_q;
  assign irq_o = (rx_rvalid & ctrl_q.rxie) | (~tx_rvalid & ctrl_q.txie);
endmodule
